// File: rtl/piece_bag_queue_if.sv
// piece_bag_queue_if: piece-stream handshake between the game FSM / seed
// generator (master) and the piece bag queue (slave).
interface piece_bag_queue_if #(
    parameter int DEPTH = 3
);
    logic [2:0]         seed;
    logic               pop;
    logic               hold;
    logic               piece_valid;
    logic [2:0]         piece;
    logic [3*DEPTH-1:0] queue_flat;
    logic [2:0]         count;
    logic               held_valid;
    logic [2:0]         held;

    modport master (
        output seed, pop, hold,
        input  piece_valid, piece, queue_flat, count, held_valid, held
    );

    modport slave (
        input  seed, pop, hold,
        output piece_valid, piece, queue_flat, count, held_valid, held
    );
endinterface

// File: rtl/piece_bag_queue.sv
// piece_bag_queue: turns a free-running 3-bit seed into a 7-bag randomised
// piece stream and buffers it in a DEPTH-entry preview FIFO (entry 0 is the
// current piece). Optional hold slot is compiled in when HOLD_EN is defined.
module piece_bag_queue #(
    parameter int DEPTH = 3,
    parameter int PW    = 3
) (
    input logic              CLK,
    input logic              reset,
    piece_bag_queue_if.slave bus
);
    typedef enum logic {FILL = 1'b0, READY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] entry_q [DEPTH];
    logic [PW-1:0] entry_d [DEPTH];
    logic [PW-1:0] shifted_s [DEPTH];
    logic [2:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic [6:0]    mask_q, mask_d;
    logic [6:0]    mask_set_s;
    logic [7:0]    mask_ext_s;
    logic [2:0]    cand_s;
    logic [2:0]    tail_s;
    logic          pop_ok_s, hold_take_s, shift_s, push_s;
`ifdef HOLD_EN
    logic [PW-1:0] held_q, held_d;
    logic          held_valid_q, held_valid_d;
    logic          lock_q, lock_d;
    logic          hold_ok_s, hold_swap_s;
`endif

    // Lowest piece value not yet used in the current bag.
    function automatic logic [2:0] lowest_free(input logic [6:0] m);
        lowest_free = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!m[i]) lowest_free = 3'(i);
        end
    endfunction

    // Decode which queue operation happens at this edge.
    always_comb begin
        pop_ok_s = bus.pop && valid_q;
`ifdef HOLD_EN
        hold_ok_s   = bus.hold && !bus.pop && valid_q && !lock_q;
        hold_take_s = hold_ok_s && !held_valid_q;
        hold_swap_s = hold_ok_s && held_valid_q;
`else
        hold_take_s = 1'b0;
`endif
        shift_s = pop_ok_s || hold_take_s;
        push_s  = (state_q == FILL) || shift_s;
    end

    // Pick the push candidate and advance the bag mask; a full bag restarts empty.
    always_comb begin
        mask_ext_s = {1'b1, mask_q};    // seed 7 always looks used
        if (!mask_ext_s[bus.seed]) cand_s = bus.seed;
        else                       cand_s = lowest_free(mask_q);
        mask_set_s = mask_q | (7'd1 << cand_s);
        if (!push_s)                    mask_d = mask_q;
        else if (mask_set_s == 7'h7F)   mask_d = 7'h00;
        else                            mask_d = mask_set_s;
    end

    // Shift/swap the queue and write the pushed piece at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) shifted_s[i] = entry_q[i];
        tail_s = count_q;
        if (shift_s) begin
            for (int i = 0; i < DEPTH - 1; i++) shifted_s[i] = entry_q[i + 1];
            shifted_s[DEPTH - 1] = '0;
            tail_s = count_q - 3'd1;
        end else begin
`ifdef HOLD_EN
            if (hold_swap_s) shifted_s[0] = held_q;
            else             shifted_s[0] = entry_q[0];
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = (push_s && (tail_s == 3'(i))) ? cand_s : shifted_s[i];
        end
    end

    // Occupancy count and FILL/READY state; READY is left only through reset.
    always_comb begin
        if (push_s && !shift_s) count_d = count_q + 3'd1;
        else                    count_d = count_q;
        valid_d = (count_d != 3'd0);
        case (state_q)
            FILL: begin
                if (count_d == 3'(DEPTH)) state_d = READY;
                else                      state_d = FILL;
            end
            READY:   state_d = READY;
            default: state_d = FILL;
        endcase
    end

    // Queue, mask and state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= FILL;
            count_q <= 3'd0;
            valid_q <= 1'b0;
            mask_q  <= 7'h00;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            valid_q <= valid_d;
            mask_q  <= mask_d;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end

`ifdef HOLD_EN
    // Hold slot next state: take on first hold, swap afterwards, lock until a pop.
    always_comb begin
        held_d       = held_q;
        held_valid_d = held_valid_q;
        lock_d       = lock_q;
        if (hold_ok_s) begin
            held_d       = entry_q[0];
            held_valid_d = 1'b1;
            lock_d       = 1'b1;
        end else if (pop_ok_s) begin
            lock_d       = 1'b0;
        end else begin
            lock_d       = lock_q;
        end
    end

    // Hold slot registers.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            held_q       <= '0;
            held_valid_q <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            lock_q       <= lock_d;
        end
    end

    assign bus.held       = held_q;
    assign bus.held_valid = held_valid_q;
`else
    assign bus.held       = 3'd0;
    assign bus.held_valid = 1'b0;
`endif

    assign bus.piece       = entry_q[0];
    assign bus.piece_valid = valid_q;
    assign bus.count       = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign bus.queue_flat[PW*g +: PW] = entry_q[g];
    end
endmodule

// File: tb/tb_piece_bag_queue.sv
// Self-checking bench for piece_bag_queue: queue/bag-set reference model,
// per-cycle compare on the falling edge, plus literal scenario checks.
module tb_piece_bag_queue;
    localparam int DEPTH = 3;
`ifdef HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset = 1'b0;
    piece_bag_queue_if #(.DEPTH(DEPTH)) bus();

    piece_bag_queue #(.DEPTH(DEPTH), .PW(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int       mq[$];
    bit [6:0] mused = '0;
    int       m_held = 0;
    bit       m_held_valid = 1'b0;
    bit       m_lock = 1'b0;
    int       pushed[$];
    bit       check_en = 1'b0;
    int       n_checks = 0;
    int       n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply one clock edge using the inputs currently driven.
    task automatic model_edge();
        int  c, sd, f, t;
        bit  valid, pop_ok, hold_ok, take, swap, remove, do_push;
        if (!reset) begin
            mq.delete(); pushed.delete();
            mused = '0; m_held = 0; m_held_valid = 1'b0; m_lock = 1'b0;
            return;
        end
        sd = int'(bus.seed);
        if (sd <= 6 && !mused[sd]) c = sd;
        else begin
            c = -1;
            for (int v = 0; v < 7; v++) if (c < 0 && !mused[v]) c = v;
        end
        valid   = (mq.size() > 0);
        pop_ok  = bus.pop && valid;
        hold_ok = HOLD_ON && bus.hold && !bus.pop && valid && !m_lock;
        take    = hold_ok && !m_held_valid;
        swap    = hold_ok && m_held_valid;
        remove  = pop_ok || take;
        do_push = (mq.size() < DEPTH) || remove;
        if (remove) begin
            f = mq.pop_front();
            if (take) begin m_held = f; m_held_valid = 1'b1; end
        end
        if (swap) begin t = mq[0]; mq[0] = m_held; m_held = t; end
        if (do_push) begin
            mq.push_back(c);
            pushed.push_back(c);
            mused[c] = 1'b1;
            if (mused == 7'h7F) mused = '0;
        end
        if (hold_ok) m_lock = 1'b1;
        else if (pop_ok) m_lock = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic check_perm(input string name);
        bit [6:0] s;
        for (int g = 0; g + 7 <= pushed.size(); g += 7) begin
            s = '0;
            for (int k = 0; k < 7; k++) s[pushed[g + k]] = 1'b1;
            chk(name, s, 7'h7F);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        logic [3*DEPTH-1:0] exp_flat;
        if (check_en) begin
            exp_flat = '0;
            for (int i = 0; i < mq.size(); i++) exp_flat[3*i +: 3] = 3'(mq[i]);
            chk("count", bus.count, mq.size());
            chk("piece_valid", bus.piece_valid, (mq.size() > 0));
            chk("piece", bus.piece, (mq.size() > 0) ? mq[0] : 0);
            chk("queue_flat", bus.queue_flat, exp_flat);
            chk("held_valid", bus.held_valid, m_held_valid);
            chk("held", bus.held, m_held);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pops, cyc;
        int popped[$];
        bus.seed = 3'd0; bus.pop = 1'b0; bus.hold = 1'b0;

        // Pop during reset and on the first cycle after release is ignored.
        reset = 1'b0; bus.pop = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        chk("reset_count", bus.count, 0);
        chk("reset_valid", bus.piece_valid, 0);
        reset = 1'b1;
        tick();
        chk("pop_at_empty_count", bus.count, 1);
        chk("pop_at_empty_piece", bus.piece, 0);
        tick();
        chk("pop_refill_count", bus.count, 1);
        chk("pop_refill_piece", bus.piece, 1);
        bus.pop = 1'b0;

        // Seed held at 3: queue fills to 3,0,1.
        reset = 1'b0; tick(); reset = 1'b1;
        bus.seed = 3'd3;
        tick(); chk("fill1_count", bus.count, 1);
        tick(); chk("fill2_count", bus.count, 2);
        tick();
        chk("fill_flat", bus.queue_flat, 9'b001_000_011);
        chk("fill_count", bus.count, 3);
        chk("fill_piece", bus.piece, 3);

        // Hold scenario, pieces 2 and 4 pending (seed 7 -> lowest free).
        bus.seed = 3'd7;
        bus.hold = 1'b1; tick();
`ifdef HOLD_EN
        chk("hold_take_held", bus.held, 3);
        chk("hold_take_piece", bus.piece, 0);
        tick();
        chk("hold_locked_held", bus.held, 3);
        chk("hold_locked_flat", bus.queue_flat, 9'b010_001_000);
        bus.hold = 1'b0; bus.pop = 1'b1; tick();
        bus.pop = 1'b0; bus.hold = 1'b1; tick();
        chk("hold_swap_piece", bus.piece, 3);
        chk("hold_swap_held", bus.held, 1);
`else
        chk("hold_ignored_piece", bus.piece, 3);
        chk("hold_ignored_held_valid", bus.held_valid, 0);
`endif
        bus.hold = 1'b0;

        // Seed stuck at 7: popped sequence cycles 0..6.
        reset = 1'b0; tick(); reset = 1'b1;
        tick(); tick(); tick();
        bus.pop = 1'b1;
        for (int k = 0; k < 14; k++) begin
            popped.push_back(int'(bus.piece));
            tick();
        end
        bus.pop = 1'b0;
        for (int k = 0; k < 14; k++) chk("stuck7_seq", popped[k], k % 7);

        // Random seeds, pops and holds until 700 honoured pops.
        reset = 1'b0; tick(); reset = 1'b1;
        pops = 0; cyc = 0;
        while (pops < 700 && cyc < 5000) begin
            bus.seed = 3'($urandom_range(0, 7));
            bus.pop  = ($urandom_range(0, 3) != 0);
            bus.hold = ($urandom_range(0, 7) == 0);
            if (bus.pop && mq.size() > 0) pops++;
            tick();
            cyc++;
        end
        bus.pop = 1'b0; bus.hold = 1'b0;
        chk("random_pops_done", pops, 700);
        check_perm("random_perm");

        // Mid-stream reset flushes everything; next bag is a full permutation.
        bus.seed = 3'd5;
        tick(); tick();
        reset = 1'b0; tick();
        chk("midreset_count", bus.count, 0);
        chk("midreset_flat", bus.queue_flat, 0);
        chk("midreset_valid", bus.piece_valid, 0);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.seed = 3'($urandom_range(0, 7));
            bus.pop  = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.pop = 1'b0;
        chk("midreset_enough_pushes", (pushed.size() >= 14), 1);
        check_perm("midreset_perm");

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
